// File: rtl/hpss_frame_sequencer.sv
// Frame sequencer for the HPSS FFT -> IFFT pipeline: one forward FFT, a result transfer and an IFFT drain per frame.
// Optional wait-state watchdog is compiled in with `define HPSS_SEQ_TIMEOUT_EN.
module hpss_frame_sequencer #(
    parameter int FRAME_LEN   = 1024,
    parameter int ADDR_W      = 10,
    parameter int LVL_W       = 12,
    parameter int IN_THRESH   = 1500,
    parameter int OUT_HI      = 2047,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n2,
    input  logic              enable,
    input  logic [LVL_W-1:0]  wr_water_level,
    output logic              data_en,
    output logic              fft_start,
    input  logic              fft_finish,
    output logic              fft_rd_en,
    output logic [ADDR_W-1:0] fft_addr,
    output logic              ifft_start,
    input  logic              ifft_finish,
    output logic              ifft_rd_en,
    output logic [ADDR_W-1:0] ifft_addr,
    input  logic [LVL_W-1:0]  rd_water_level_out,
    output logic              voice_en_out,
    output logic              busy,
    output logic [15:0]       frame_cnt,
    output logic              timeout_err
);

    typedef enum logic [2:0] {
        IDLE,
        FFT_START,
        FFT_WAIT,
        XFER,
        IFFT_WAIT,
        DRAIN
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);
    localparam logic [LVL_W-1:0]  IN_LVL    = LVL_W'(IN_THRESH);
    localparam logic [LVL_W-1:0]  OUT_LVL   = LVL_W'(OUT_HI);

    state_t            state_q;
    logic              fft_start_q;
    logic              fft_rd_en_q;
    logic [ADDR_W-1:0] fft_addr_q;
    logic              ifft_start_q;
    logic              ifft_rd_en_q;
    logic [ADDR_W-1:0] ifft_addr_q;
    logic              busy_q;
    logic [15:0]       frame_cnt_q;
    logic              data_en_q;
    logic              data_en_d;
    logic              voice_en_q;
    logic              voice_en_d;

`ifdef HPSS_SEQ_TIMEOUT_EN
    localparam int              TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] wait_cnt_q;
    logic            timeout_err_q;
    logic            wait_expired;

    // The cycle in which the counter holds TIMEOUT_CYC-1 is the last allowed wait cycle.
    assign wait_expired = (wait_cnt_q == TO_LAST);
    assign timeout_err  = timeout_err_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYC;
    assign timeout_err        = 1'b0;
`endif

    assign data_en_d = enable && (wr_water_level <= IN_LVL);

    // Output-FIFO gate with hysteresis; an empty FIFO always closes it.
    always_comb begin
        voice_en_d = voice_en_q;
        if (rd_water_level_out == '0) begin
            voice_en_d = 1'b0;
        end else if (rd_water_level_out >= OUT_LVL) begin
            voice_en_d = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst_n2) begin
        if (sys_rst_n2) begin
            data_en_q  <= 1'b0;
            voice_en_q <= 1'b0;
        end else begin
            data_en_q  <= data_en_d;
            voice_en_q <= voice_en_d;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst_n2) begin
        if (sys_rst_n2) begin
            state_q       <= IDLE;
            fft_start_q   <= 1'b0;
            fft_rd_en_q   <= 1'b0;
            fft_addr_q    <= '0;
            ifft_start_q  <= 1'b0;
            ifft_rd_en_q  <= 1'b0;
            ifft_addr_q   <= '0;
            busy_q        <= 1'b0;
            frame_cnt_q   <= '0;
`ifdef HPSS_SEQ_TIMEOUT_EN
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            fft_start_q  <= 1'b0;
            ifft_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_q     <= FFT_START;
                        fft_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                FFT_START: begin
                    state_q <= FFT_WAIT;
`ifdef HPSS_SEQ_TIMEOUT_EN
                    wait_cnt_q <= '0;
`endif
                end
                FFT_WAIT: begin
                    if (fft_finish) begin
                        state_q      <= XFER;
                        ifft_start_q <= 1'b1;
                        fft_rd_en_q  <= 1'b1;
                        fft_addr_q   <= '0;
`ifdef HPSS_SEQ_TIMEOUT_EN
                    end else if (wait_expired) begin
                        state_q       <= IDLE;
                        busy_q        <= 1'b0;
                        timeout_err_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
`endif
                    end
                end
                XFER: begin
                    if (fft_addr_q == LAST_ADDR) begin
                        state_q     <= IFFT_WAIT;
                        fft_rd_en_q <= 1'b0;
                        fft_addr_q  <= '0;
`ifdef HPSS_SEQ_TIMEOUT_EN
                        wait_cnt_q  <= '0;
`endif
                    end else begin
                        fft_addr_q <= fft_addr_q + 1'b1;
                    end
                end
                IFFT_WAIT: begin
                    if (ifft_finish) begin
                        state_q      <= DRAIN;
                        ifft_rd_en_q <= 1'b1;
                        ifft_addr_q  <= '0;
`ifdef HPSS_SEQ_TIMEOUT_EN
                    end else if (wait_expired) begin
                        state_q       <= IDLE;
                        busy_q        <= 1'b0;
                        timeout_err_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
`endif
                    end
                end
                DRAIN: begin
                    if (ifft_addr_q == LAST_ADDR) begin
                        ifft_rd_en_q <= 1'b0;
                        ifft_addr_q  <= '0;
                        frame_cnt_q  <= frame_cnt_q + 1'b1;
                        // Chain straight into the next frame when still enabled.
                        if (enable) begin
                            state_q     <= FFT_START;
                            fft_start_q <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        ifft_addr_q <= ifft_addr_q + 1'b1;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    busy_q       <= 1'b0;
                    fft_rd_en_q  <= 1'b0;
                    fft_addr_q   <= '0;
                    ifft_rd_en_q <= 1'b0;
                    ifft_addr_q  <= '0;
                end
            endcase
        end
    end

    assign data_en      = data_en_q;
    assign fft_start    = fft_start_q;
    assign fft_rd_en    = fft_rd_en_q;
    assign fft_addr     = fft_addr_q;
    assign ifft_start   = ifft_start_q;
    assign ifft_rd_en   = ifft_rd_en_q;
    assign ifft_addr    = ifft_addr_q;
    assign voice_en_out = voice_en_q;
    assign busy         = busy_q;
    assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_hpss_frame_sequencer.sv
// Directed self-checking bench for hpss_frame_sequencer; inputs driven and outputs sampled on the falling edge.
`timescale 1ns/1ps
module tb_hpss_frame_sequencer;

    localparam int FRAME_LEN   = 1024;
    localparam int ADDR_W      = 10;
    localparam int LVL_W       = 12;
    localparam int TIMEOUT_CYC = 100;

    logic              sys_clk            = 1'b0;
    logic              sys_rst_n2         = 1'b1;
    logic              enable             = 1'b0;
    logic [LVL_W-1:0]  wr_water_level     = 12'd2000;
    logic              fft_finish         = 1'b0;
    logic              ifft_finish        = 1'b0;
    logic [LVL_W-1:0]  rd_water_level_out = 12'd0;
    logic              data_en;
    logic              fft_start;
    logic              fft_rd_en;
    logic [ADDR_W-1:0] fft_addr;
    logic              ifft_start;
    logic              ifft_rd_en;
    logic [ADDR_W-1:0] ifft_addr;
    logic              voice_en_out;
    logic              busy;
    logic [15:0]       frame_cnt;
    logic              timeout_err;

    int n_cmp = 0;
    int n_bad = 0;

    hpss_frame_sequencer #(
        .FRAME_LEN  (FRAME_LEN),
        .ADDR_W     (ADDR_W),
        .LVL_W      (LVL_W),
        .IN_THRESH  (1500),
        .OUT_HI     (2047),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .sys_clk           (sys_clk),
        .sys_rst_n2        (sys_rst_n2),
        .enable            (enable),
        .wr_water_level    (wr_water_level),
        .data_en           (data_en),
        .fft_start         (fft_start),
        .fft_finish        (fft_finish),
        .fft_rd_en         (fft_rd_en),
        .fft_addr          (fft_addr),
        .ifft_start        (ifft_start),
        .ifft_finish       (ifft_finish),
        .ifft_rd_en        (ifft_rd_en),
        .ifft_addr         (ifft_addr),
        .rd_water_level_out(rd_water_level_out),
        .voice_en_out      (voice_en_out),
        .busy              (busy),
        .frame_cnt         (frame_cnt),
        .timeout_err       (timeout_err)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(negedge sys_clk);
    endtask

    task automatic test_reset();
        sys_rst_n2 = 1'b1;
        enable = 1'b1;
        wr_water_level = 12'd100;
        rd_water_level_out = 12'd2047;
        repeat (3) tick();
        n_cmp++;
        if ({busy, fft_start, fft_rd_en, ifft_start, ifft_rd_en, data_en, voice_en_out, timeout_err} !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_flags got %b want 00000000",
                     {busy, fft_start, fft_rd_en, ifft_start, ifft_rd_en, data_en, voice_en_out, timeout_err});
        end
        n_cmp++;
        if (fft_addr !== '0 || ifft_addr !== '0 || frame_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_counts got fa=%0d ia=%0d fc=%0d want 0 0 0", fft_addr, ifft_addr, frame_cnt);
        end
        enable = 1'b0;
        wr_water_level = 12'd2000;
        rd_water_level_out = 12'd0;
        sys_rst_n2 = 1'b0;
        tick();
        n_cmp++;
        if (busy !== 1'b0 || fft_start !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_after_release got busy=%b start=%b want 0 0", busy, fft_start);
        end
    endtask

    task automatic test_frame();
        enable = 1'b1;
        tick();
        n_cmp++;
        if (fft_start !== 1'b1 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL fft_start_pulse got start=%b busy=%b want 1 1", fft_start, busy);
        end
        tick();
        n_cmp++;
        if (fft_start !== 1'b0) begin
            n_bad++;
            $display("FAIL fft_start_width got %b want 0", fft_start);
        end
        ifft_finish = 1'b1;
        tick();
        ifft_finish = 1'b0;
        n_cmp++;
        if (ifft_rd_en !== 1'b0 || fft_rd_en !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL ifft_finish_ignored got ird=%b frd=%b busy=%b want 0 0 1", ifft_rd_en, fft_rd_en, busy);
        end
        repeat (47) tick();
        fft_finish = 1'b1;
        tick();
        for (int i = 0; i < FRAME_LEN; i++) begin
            n_cmp++;
            if (fft_rd_en !== 1'b1 || fft_addr !== ADDR_W'(i) || ifft_start !== (i == 0)) begin
                n_bad++;
                $display("FAIL fft_read[%0d] got en=%b addr=%0d istart=%b want en=1 addr=%0d istart=%b",
                         i, fft_rd_en, fft_addr, ifft_start, i, (i == 0));
            end
            fft_finish = 1'b0;
            tick();
        end
        n_cmp++;
        if (fft_rd_en !== 1'b0 || fft_addr !== '0 || ifft_rd_en !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL xfer_end got frd=%b fa=%0d ird=%b busy=%b want 0 0 0 1", fft_rd_en, fft_addr, ifft_rd_en, busy);
        end
        fft_finish = 1'b1;
        tick();
        fft_finish = 1'b0;
        n_cmp++;
        if (fft_rd_en !== 1'b0 || ifft_start !== 1'b0) begin
            n_bad++;
            $display("FAIL fft_finish_ignored got frd=%b istart=%b want 0 0", fft_rd_en, ifft_start);
        end
        repeat (29) tick();
        ifft_finish = 1'b1;
        tick();
        for (int i = 0; i < FRAME_LEN; i++) begin
            n_cmp++;
            if (ifft_rd_en !== 1'b1 || ifft_addr !== ADDR_W'(i) || frame_cnt !== 16'd0) begin
                n_bad++;
                $display("FAIL ifft_read[%0d] got en=%b addr=%0d fc=%0d want en=1 addr=%0d fc=0",
                         i, ifft_rd_en, ifft_addr, frame_cnt, i);
            end
            ifft_finish = 1'b0;
            tick();
        end
        n_cmp++;
        if (frame_cnt !== 16'd1 || fft_start !== 1'b1 || ifft_rd_en !== 1'b0 || ifft_addr !== '0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL next_frame got fc=%0d start=%b ird=%b ia=%0d busy=%b want 1 1 0 0 1",
                     frame_cnt, fft_start, ifft_rd_en, ifft_addr, busy);
        end
    endtask

    task automatic test_enable_drop();
        tick();
        repeat (4) tick();
        fft_finish = 1'b1;
        tick();
        fft_finish = 1'b0;
        repeat (5) tick();
        enable = 1'b0;
        repeat (1019) tick();
        n_cmp++;
        if (fft_rd_en !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL xfer_completes_after_drop got frd=%b busy=%b want 0 1", fft_rd_en, busy);
        end
        ifft_finish = 1'b1;
        tick();
        ifft_finish = 1'b0;
        repeat (1024) tick();
        n_cmp++;
        if (busy !== 1'b0 || fft_start !== 1'b0 || frame_cnt !== 16'd2) begin
            n_bad++;
            $display("FAIL drop_to_idle got busy=%b start=%b fc=%0d want 0 0 2", busy, fft_start, frame_cnt);
        end
        repeat (5) tick();
        n_cmp++;
        if (busy !== 1'b0 || fft_start !== 1'b0 || frame_cnt !== 16'd2) begin
            n_bad++;
            $display("FAIL idle_holds got busy=%b start=%b fc=%0d want 0 0 2", busy, fft_start, frame_cnt);
        end
    endtask

    task automatic test_reset_in_drain();
        enable = 1'b1;
        tick();
        tick();
        fft_finish = 1'b1;
        tick();
        fft_finish = 1'b0;
        repeat (1024) tick();
        ifft_finish = 1'b1;
        tick();
        ifft_finish = 1'b0;
        repeat (10) tick();
        n_cmp++;
        if (ifft_rd_en !== 1'b1 || ifft_addr !== 10'd10 || frame_cnt !== 16'd2) begin
            n_bad++;
            $display("FAIL drain_midway got ird=%b ia=%0d fc=%0d want 1 10 2", ifft_rd_en, ifft_addr, frame_cnt);
        end
        #2 sys_rst_n2 = 1'b1;
        #1;
        n_cmp++;
        if ({busy, fft_start, fft_rd_en, ifft_start, ifft_rd_en, timeout_err} !== 6'b0 ||
            ifft_addr !== '0 || fft_addr !== '0 || frame_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL async_reset_drain got flags=%b ia=%0d fa=%0d fc=%0d want 000000 0 0 0",
                     {busy, fft_start, fft_rd_en, ifft_start, ifft_rd_en, timeout_err}, ifft_addr, fft_addr, frame_cnt);
        end
        repeat (2) tick();
        n_cmp++;
        if ({busy, fft_start, fft_rd_en, ifft_start, ifft_rd_en} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_no_pulses got %b want 00000", {busy, fft_start, fft_rd_en, ifft_start, ifft_rd_en});
        end
        enable = 1'b0;
        sys_rst_n2 = 1'b0;
        tick();
        enable = 1'b1;
        tick();
        n_cmp++;
        if (fft_start !== 1'b1 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL resume_after_reset got start=%b busy=%b want 1 1", fft_start, busy);
        end
    endtask

    task automatic test_data_en();
        logic [LVL_W-1:0] lvl [4];
        logic             exp [4];
        logic             prev;
        lvl = '{12'd1499, 12'd1500, 12'd1501, 12'd1499};
        exp = '{1'b1, 1'b1, 1'b0, 1'b1};
        enable = 1'b1;
        wr_water_level = 12'd2000;
        tick();
        n_cmp++;
        if (data_en !== 1'b0) begin
            n_bad++;
            $display("FAIL data_en_above got %b want 0", data_en);
        end
        prev = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_water_level = lvl[i];
            #1;
            n_cmp++;
            if (data_en !== prev) begin
                n_bad++;
                $display("FAIL data_en_latency[%0d] got %b want %b", i, data_en, prev);
            end
            tick();
            n_cmp++;
            if (data_en !== exp[i]) begin
                n_bad++;
                $display("FAIL data_en[%0d] lvl=%0d got %b want %b", i, lvl[i], data_en, exp[i]);
            end
            prev = exp[i];
        end
        enable = 1'b0;
        wr_water_level = 12'd100;
        tick();
        n_cmp++;
        if (data_en !== 1'b0) begin
            n_bad++;
            $display("FAIL data_en_disabled got %b want 0", data_en);
        end
    endtask

    task automatic test_voice_gate();
        logic [LVL_W-1:0] lvl [5];
        logic             exp [5];
        logic             prev;
        lvl = '{12'd2046, 12'd2047, 12'd1000, 12'd0, 12'd3000};
        exp = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        prev = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rd_water_level_out = lvl[i];
            #1;
            n_cmp++;
            if (voice_en_out !== prev) begin
                n_bad++;
                $display("FAIL voice_latency[%0d] got %b want %b", i, voice_en_out, prev);
            end
            tick();
            n_cmp++;
            if (voice_en_out !== exp[i]) begin
                n_bad++;
                $display("FAIL voice_en[%0d] lvl=%0d got %b want %b", i, lvl[i], voice_en_out, exp[i]);
            end
            prev = exp[i];
        end
        rd_water_level_out = 12'd0;
        tick();
    endtask

    task automatic test_timeout();
        sys_rst_n2 = 1'b1;
        enable = 1'b0;
        tick();
        sys_rst_n2 = 1'b0;
        enable = 1'b1;
        tick();
        n_cmp++;
        if (fft_start !== 1'b1) begin
            n_bad++;
            $display("FAIL wd_start got %b want 1", fft_start);
        end
        enable = 1'b0;
`ifdef HPSS_SEQ_TIMEOUT_EN
        repeat (TIMEOUT_CYC) tick();
        n_cmp++;
        if (timeout_err !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL before_timeout got err=%b busy=%b want 0 1", timeout_err, busy);
        end
        tick();
        n_cmp++;
        if (timeout_err !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_fire got err=%b busy=%b want 1 0", timeout_err, busy);
        end
        repeat (3) tick();
        n_cmp++;
        if (timeout_err !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_sticky got err=%b busy=%b want 1 0", timeout_err, busy);
        end
`else
        repeat (2 * TIMEOUT_CYC) tick();
        n_cmp++;
        if (timeout_err !== 1'b0 || busy !== 1'b1 || fft_rd_en !== 1'b0) begin
            n_bad++;
            $display("FAIL wait_forever got err=%b busy=%b frd=%b want 0 1 0", timeout_err, busy, fft_rd_en);
        end
`endif
        sys_rst_n2 = 1'b1;
        tick();
        sys_rst_n2 = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_frame();
        test_enable_drop();
        test_reset_in_drain();
        test_data_en();
        test_voice_gate();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got no completion want finish within 2 ms");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/hpss_frame_sequencer.md
HPSS_FRAME_SEQUENCER -- requirements
Module: hpss_frame_sequencer

Interface
REQ-001 Parameters, one per line, SHALL be:
- FRAME_LEN, 1024, points per FFT/IFFT frame.
- ADDR_W, 10, frame address width.
- LVL_W, 12, FIFO water-level width.
- IN_THRESH, 1500, input request threshold.
- OUT_HI, 2047, output-gate set level.
- TIMEOUT_CYC, 65535, watchdog limit in cycles.
REQ-002 Clocking: reset sys_rst_n2, asynchronous, active-high; clock sys_clk.
REQ-003 Ports, one per line:
- sys_clk  in  1  clock.
- sys_rst_n2  in  1  asynchronous active-high reset.
- enable  in  1  run request.
- wr_water_level  in  LVL_W  input FIFO fill level.
- data_en  out  1  input sample request.
- fft_start  out  1  forward FFT start pulse.
- fft_finish  in  1  forward FFT done pulse.
- fft_rd_en  out  1  FFT result read strobe.
- fft_addr  out  ADDR_W  FFT result read address.
- ifft_start  out  1  IFFT start pulse.
- ifft_finish  in  1  IFFT done pulse.
- ifft_rd_en  out  1  IFFT result read strobe.
- ifft_addr  out  ADDR_W  IFFT result read address.
- rd_water_level_out  in  LVL_W  output FIFO fill level.
- voice_en_out  out  1  output FIFO read enable.
- busy  out  1  high whenever state is not IDLE.
- frame_cnt  out  16  completed frames, wraps at 65535 to 0.
- timeout_err  out  1  sticky watchdog flag.

Function
REQ-004 All outputs SHALL be registered.
REQ-005 States SHALL be IDLE, FFT_START, FFT_WAIT, XFER, IFFT_WAIT, DRAIN.
REQ-006 IDLE SHALL go to FFT_START when enable=1.
REQ-007 FFT_START SHALL last 1 cycle, assert fft_start=1 for exactly that cycle, then go to FFT_WAIT.
REQ-008 FFT_WAIT SHALL go to XFER on fft_finish=1. fft_finish SHALL be ignored in every other state.
REQ-009 On XFER entry the block SHALL assert ifft_start=1 for 1 cycle, coincident with fft_rd_en=1 and fft_addr=0.
REQ-010 In XFER, fft_rd_en SHALL stay 1 for exactly FRAME_LEN consecutive cycles, with fft_addr incrementing by 1 each cycle. After address FRAME_LEN-1 the state SHALL go to IFFT_WAIT and fft_addr SHALL return to 0.
REQ-011 IFFT_WAIT SHALL go to DRAIN on ifft_finish=1. ifft_finish SHALL be ignored elsewhere.
REQ-012 DRAIN SHALL sweep ifft_rd_en and ifft_addr 0..FRAME_LEN-1 the same way as REQ-010. At the end it SHALL increment frame_cnt, then go to FFT_START if enable=1, else IDLE.
REQ-013 Deasserting enable mid-frame SHALL NOT abort the frame; the current frame SHALL complete through DRAIN.
REQ-014 data_en SHALL equal the registered value of (enable AND wr_water_level <= IN_THRESH), with 1-cycle latency. At wr_water_level=IN_THRESH, data_en SHALL be 1.
REQ-015 voice_en_out SHALL be set when rd_water_level_out >= OUT_HI and cleared when rd_water_level_out == 0, otherwise held. Clear SHALL take priority.

Reset
REQ-016 While sys_rst_n2=1, the block SHALL be in IDLE with every output 0, including addresses, frame_cnt and timeout_err.
REQ-017 Reset asserted mid-frame SHALL abort immediately, with no further start or read pulses.
REQ-018 After reset release, operation SHALL resume from IDLE on the first sys_clk edge.

Configuration
REQ-019 With HPSS_SEQ_TIMEOUT_EN defined, a counter SHALL run in FFT_WAIT and IFFT_WAIT and restart on each state entry. When it reaches TIMEOUT_CYC, timeout_err SHALL be set (sticky until reset) and the state SHALL go to IDLE.
REQ-020 Without HPSS_SEQ_TIMEOUT_EN, the wait states SHALL wait indefinitely and timeout_err SHALL be tied to 0.

Verification
REQ-021 Reset release, enable=1, fft_finish 50 cycles after fft_start -> ifft_start and fft_addr=0 appear 1 cycle later; 1024 reads, 0..1023.
REQ-022 ifft_finish 30 cycles into IFFT_WAIT -> ifft_addr sweeps 0..1023, frame_cnt=1, next fft_start follows with no gap state.
REQ-023 wr_water_level stepped 1499, 1500, 1501 -> data_en 1, 1, 0, each with 1-cycle latency.
REQ-024 rd_water_level_out driven 2046, 2047, 1000, 0 -> voice_en_out 0, 1, 1, 0.
REQ-025 enable dropped during XFER -> frame completes, state goes to IDLE, frame_cnt increments once. Reset pulsed in DRAIN -> all outputs 0 that cycle.
REQ-026 With HPSS_SEQ_TIMEOUT_EN defined and TIMEOUT_CYC=100, fft_finish withheld -> timeout_err=1 after 100 wait cycles, busy=0.
